// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Wide adder built from one shared 4-bit ripple-carry adder. The adder is used
//   once per clock, least significant nibble first, so a 4*NIBBLES-bit add takes
//   NIBBLES cycles plus one DONE cycle. A registered carry links each nibble to
//   the next.
//   Optional feature macro: ADDER_SUBTRACT_EN. When it is defined, sub=1 at
//   accept computes X - Y. When it is not defined, the sub port is ignored.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] X,
  input  logic [4*NIBBLES-1:0] Y,
  input  logic                 Cin,
  input  logic                 sub,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] S,
  output logic                 Cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  opx;
  logic [W-1:0]  opy;

  // Operand B and the carry-in as they will be latched at accept.
  logic [W-1:0]  y_in;
  logic          cin_in;

  // One nibble slice and the shared adder result.
  logic [3:0]    x_nib;
  logic [3:0]    y_nib;
  logic [3:0]    nib_sum;
  logic          nib_cout;

  // Select the latched B operand and carry-in, inverted for subtraction when enabled.
`ifdef ADDER_SUBTRACT_EN
  always_comb begin
    y_in   = sub ? ~Y : Y;
    cin_in = sub ? 1'b1 : Cin;
  end
`else
  // sub is kept on the port list for pin compatibility but carries no logic.
  logic sub_unused;
  assign sub_unused = sub;

  always_comb begin
    y_in   = Y;
    cin_in = Cin;
  end
`endif

  // Pick the nibble addressed by idx from each latched operand.
  always_comb begin
    x_nib = opx[{idx, 2'b00} +: 4];
    y_nib = opy[{idx, 2'b00} +: 4];
  end

  // Shared 4-bit ripple-carry adder.
  always_comb begin
    logic c;
    // NOTE: every variable gets a value before any conditional or loop use, so no latch is inferred.
    c        = carry;
    nib_sum  = '0;
    for (int b = 0; b < 4; b++) begin
      nib_sum[b] = x_nib[b] ^ y_nib[b] ^ c;
      c          = (x_nib[b] & y_nib[b]) | (c & (x_nib[b] ^ y_nib[b]));
    end
    nib_cout = c;
  end

  // Sequencer: accept, walk the nibbles LSB first, then report for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      // NOTE: operand registers are reset as well, so an aborted add leaves nothing behind.
      opx   <= '0;
      opy   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to this edge's old values.
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            opx   <= X;
            opy   <= y_in;
            carry <= cin_in;
            idx   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            ovf   <= 1'b0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          S[{idx, 2'b00} +: 4] <= nib_sum;
          carry                <= nib_cout;
          if (idx == LAST_IDX) begin
            // nib_sum[3] is the final S[W-1] being written on this edge.
            Cout  <= nib_cout;
            ovf   <= (opx[W-1] == opy[W-1]) && (nib_sum[3] != opx[W-1]);
            state <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status decode straight from the state register.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl
//   Directed and random adds against a whole-word arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         ovf;

  int n_total;
  int n_bad;

  logic [W-1:0] exp_s;
  logic         exp_cout;
  logic         exp_ovf;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Cin   (Cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present an operation with start=1 (caller is at a falling edge) and
  // compute the expected result from whole-word arithmetic.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s);
    logic [W-1:0] yp;
    logic         cp;
    logic [W:0]   full;
    yp = y;
    cp = c;
`ifdef ADDER_SUBTRACT_EN
    if (s) begin
      yp = ~y;
      cp = 1'b1;
    end
`endif
    full     = {1'b0, x} + {1'b0, yp} + (W+1)'(cp);
    exp_s    = full[W-1:0];
    exp_cout = full[W];
    exp_ovf  = (x[W-1] == yp[W-1]) && (full[W-1] != x[W-1]);
    X = x; Y = y; Cin = c; sub = s; start = 1'b1;
  endtask

  // Let the accept edge pass, scramble inputs during RUN, then check the
  // busy window and the DONE cycle. Returns at the DONE falling edge.
  task automatic finish_op(input bit hold, input string tag);
    @(posedge clk); #1;
    X = W'($urandom); Y = W'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
    start = hold ? 1'b1 : 1'($urandom);
    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge clk);
      check({tag, ".busy"}, busy, 1'b1);
      check({tag, ".nodone"}, done, 1'b0);
      X = W'($urandom); Y = W'($urandom);
      if (!hold) start = 1'($urandom);
    end
    @(negedge clk);
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".idle"}, busy, 1'b0);
    check({tag, ".S"}, S, exp_s);
    check({tag, ".Cout"}, Cout, exp_cout);
    check({tag, ".ovf"}, ovf, exp_ovf);
    if (!hold) start = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0; start = 1'b0; X = '0; Y = '0; Cin = 1'b0; sub = 1'b0;

    #3;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.S", S, '0);
    check("rst.Cout", Cout, 1'b0);
    check("rst.ovf", ovf, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry ripples across a nibble boundary.
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0); finish_op(0, "t1");
    @(negedge clk);
    check("t1.pulse", done, 1'b0);
    check("t1.holdS", S, exp_s);

    // Full wrap with carry out, then signed overflow.
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); finish_op(0, "t2a");
    @(negedge clk);
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); finish_op(0, "t2b");
    @(negedge clk);
    start_op(16'h8000, 16'h8000, 1'b0, 1'b0); finish_op(0, "t2c");
    @(negedge clk);

    // Carry-in used; inputs scrambled mid-RUN by finish_op.
    start_op(16'h1234, 16'h1111, 1'b1, 1'b0); finish_op(0, "t3");
    @(negedge clk);

    // start held high: back-to-back accepts from DONE.
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0); finish_op(1, "t4a");
    start_op(16'h0002, 16'h0002, 1'b0, 1'b0); finish_op(1, "t4b");
    start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom)); finish_op(0, "t4c");
    @(negedge clk);

    // Reset in the middle of an add.
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("t5.partial", (S != '0), 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5.S", S, '0);
    check("t5.busy", busy, 1'b0);
    check("t5.done", done, 1'b0);
    check("t5.Cout", Cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h0003, 16'h0004, 1'b0, 1'b0); finish_op(0, "t5b");
    @(negedge clk);

    // Subtract request: honoured only when the feature is built in.
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1); finish_op(0, "t6");
    @(negedge clk);

    // Random operations, some back-to-back.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      if (i % 6 == 0) a = 16'h7FFF;
      if (i % 6 == 1) b = 16'h8000;
      start_op(a, b, 1'($urandom), 1'($urandom));
      finish_op(i % 3 == 0, $sformatf("rnd%0d", i));
      if (i % 3 != 0) @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("end.idle", done, 1'b0);
    check("end.holdS", S, exp_s);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
